// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: holds HI/LO, runs mult/div operations over a
// fixed busy period and writes the result at completion.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_t;

    state_t             r_state;
    state_t             w_next;
    op_t                r_op;
    op_t                w_op;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [31:0]        r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic               w_is_long;
    logic               w_is_mul;
    logic               w_launch;
    logic signed [63:0] w_smul;
    logic [63:0]        w_umul;
    logic [31:0]        w_div_b;
    logic [31:0]        w_sq;
    logic [31:0]        w_sr;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;
    logic               w_res_wr;

    assign w_op      = op_t'(mdop);
    assign w_is_mul  = (w_op == OP_MULT) || (w_op == OP_MULTU);
    assign w_is_long = start && (w_is_mul || (w_op == OP_DIV) || (w_op == OP_DIVU));
    assign w_launch  = (r_state == S_IDLE) && w_is_long;

    assign busy     = (r_state == S_RUN);
    assign md_stall = busy | w_is_long;
    assign hi       = r_hi;
    assign lo       = r_lo;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state: launch a long op from IDLE, leave RUN when the counter expires
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_next = S_RUN;
            S_RUN:   if (r_cnt == '0) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Result from latched operands; divisor forced nonzero so the divide never
    // sees zero (the write is suppressed for that case anyway)
    always_comb begin
        w_smul   = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
        w_umul   = {32'b0, r_a} * {32'b0, r_b};
        w_div_b  = (r_b == '0) ? 32'd1 : r_b;
        if ((r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF)) begin
            w_sq = 32'h8000_0000;
            w_sr = '0;
        end else begin
            w_sq = $signed(r_a) / $signed(w_div_b);
            w_sr = $signed(r_a) % $signed(w_div_b);
        end
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        w_res_wr = 1'b0;
        case (r_op)
            OP_MULT: begin
                w_res_hi = w_smul[63:32];
                w_res_lo = w_smul[31:0];
                w_res_wr = 1'b1;
            end
            OP_MULTU: begin
                w_res_hi = w_umul[63:32];
                w_res_lo = w_umul[31:0];
                w_res_wr = 1'b1;
            end
            OP_DIV: begin
                w_res_hi = w_sr;
                w_res_lo = w_sq;
                w_res_wr = (r_b != '0);
            end
            OP_DIVU: begin
                w_res_hi = r_a % w_div_b;
                w_res_lo = r_a / w_div_b;
                w_res_wr = (r_b != '0);
            end
            default: w_res_wr = 1'b0;
        endcase
    end

    // Operand latch, busy counter and HI/LO updates
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op  <= OP_NONE;
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_launch) begin
                r_op  <= w_op;
                r_a   <= a;
                r_b   <= b;
                r_cnt <= w_is_mul ? 32'(MULT_CYCLES - 1) : 32'(DIV_CYCLES - 1);
            end else if (start && (w_op == OP_MTHI)) begin
                r_hi <= a;
            end else if (start && (w_op == OP_MTLO)) begin
                r_lo <= a;
            end
        end else begin
            if (r_cnt == '0) begin
                if (w_res_wr) begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
            end else begin
                r_cnt <= r_cnt - 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: expected {hi,lo} pushed at issue, popped and
// compared when the operation completes.
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    e_mdu #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mdop    (mdop),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .md_stall(md_stall),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one instruction for one edge; checks the combinational stall in IDLE
    task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        start = 1'b1;
        mdop  = op;
        a     = av;
        b     = bv;
        #1;
        check("md_stall_issue", {63'b0, md_stall}, {63'b0, (op >= 3'd1 && op <= 3'd4)});
        @(posedge clk);
        #1;
        start = 1'b0;
        mdop  = 3'd0;
    endtask

    task automatic pop_check(input string tag);
        logic [63:0] exp;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            exp = sb_q.pop_front();
            check(tag, {hi, lo}, exp);
            {m_hi, m_lo} = exp;
        end
    endtask

    // Long op: count busy cycles, require HI/LO hold, optionally inject an mtlo
    task automatic run_long(input string tag, input logic [2:0] op, input logic [31:0] av,
                            input logic [31:0] bv, input int unsigned n,
                            input logic [63:0] exp, input bit inject);
        int unsigned cnt;
        sb_q.push_back(exp);
        issue(op, av, bv);
        @(negedge clk);
        cnt = 0;
        while (busy === 1'b1 && cnt < 60) begin
            check({tag, "_hold"}, {hi, lo}, {m_hi, m_lo});
            check({tag, "_stall_busy"}, {63'b0, md_stall}, 64'd1);
            cnt++;
            if (inject && cnt == 2) begin
                start = 1'b1;
                mdop  = 3'd6;
                a     = 32'h0000_0001;
            end else begin
                start = 1'b0;
                mdop  = 3'd0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        mdop  = 3'd0;
        check({tag, "_busy_len"}, 64'(cnt), 64'(n));
        pop_check(tag);
        check({tag, "_stall_idle"}, {63'b0, md_stall}, 64'd0);
    endtask

    task automatic run_mt(input string tag, input logic [2:0] op, input logic [31:0] av);
        if (op == 3'd5) sb_q.push_back({av, m_lo});
        else            sb_q.push_back({m_hi, av});
        issue(op, av, 32'h0);
        @(negedge clk);
        check({tag, "_busy"}, {63'b0, busy}, 64'd0);
        pop_check(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mdop  = 3'd0;
        a     = '0;
        b     = '0;
        m_hi  = '0;
        m_lo  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;

        // Reset during a mult discards the pending result
        issue(3'd1, 32'd3, 32'd4);
        repeat (3) @(negedge clk);
        check("midop_busy3", {63'b0, busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midop_busy", {63'b0, busy}, 64'd0);
        check("midop_hilo", {hi, lo}, 64'd0);
        repeat (8) @(negedge clk);
        check("midop_nowrite", {hi, lo}, 64'd0);
        check("midop_idle", {63'b0, busy}, 64'd0);

        run_mt("mthi_dead", 3'd5, 32'hDEAD_BEEF);
        run_mt("mtlo_2222", 3'd6, 32'h0000_2222);

        run_long("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1);
        run_long("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, 5, 64'h0000_0002_FFFF_FFFA, 1'b0);
        run_long("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        run_long("divu", 3'd4, 32'd7, 32'd2, 10, 64'h0000_0001_0000_0003, 1'b0);
        run_long("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 64'h0000_0000_8000_0000, 1'b0);

        run_mt("mthi_1234", 3'd5, 32'h0000_1234);
        run_mt("mtlo_5678", 3'd6, 32'h0000_5678);
        run_long("divu_zero", 3'd4, 32'd9, 32'd0, 10, 64'h0000_1234_0000_5678, 1'b0);
        run_long("div_zero", 3'd3, 32'hFFFF_FFF9, 32'd0, 10, 64'h0000_1234_0000_5678, 1'b0);

        // Reserved and none opcodes with start high do nothing
        issue(3'd7, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        check("rsvd_busy", {63'b0, busy}, 64'd0);
        check("rsvd_hilo", {hi, lo}, {m_hi, m_lo});
        issue(3'd0, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        check("none_busy", {63'b0, busy}, 64'd0);
        check("none_hilo", {hi, lo}, {m_hi, m_lo});
        check("bubble_stall", {63'b0, md_stall}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
